// File: rtl/remote_move_apply.sv
// remote_move_apply: replays the opponent's take/down messages onto the local card map
// and tracks the card held by the opponent between the take and the down.
`ifndef P1
`define P1 0
`endif
`ifndef P2
`define P2 1
`endif
`ifndef GAME_P1_WAIT_IN
`define GAME_P1_WAIT_IN 4'd3
`endif
`ifndef GAME_P2_WAIT_IN
`define GAME_P2_WAIT_IN 4'd4
`endif
`ifndef MSG_TABLE_TAKE
`define MSG_TABLE_TAKE 4'd1
`endif
`ifndef MSG_TABLE_DOWN
`define MSG_TABLE_DOWN 4'd2
`endif
`ifndef MSG_HAND_DOWN
`define MSG_HAND_DOWN 4'd3
`endif

module remote_move_apply #(
    parameter int PLAYER = `P1,
    parameter logic [5:0] EMPTY_CARD = 6'd54
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         interboard_rst,
    input  logic [3:0]   cur_game_state,
    input  logic         inter_en,
    input  logic [3:0]   inter_msg_type,
    input  logic [4:0]   inter_block_x,
    input  logic [2:0]   inter_block_y,
    input  logic [5:0]   inter_card,
    input  logic [863:0] map,
    output logic         rx_ready,
    output logic         map_wr_en,
    output logic [6:0]   map_wr_addr,
    output logic [5:0]   map_wr_data,
    output logic [5:0]   held_card,
    output logic         remote_move_done,
    output logic         proto_err
);
    typedef enum logic [2:0] {IDLE, WR_TAKE, HOLD, WR_DOWN, DONE} state_t;

    state_t      state, state_n;
    logic [5:0]  held_n, data_n;
    logic [6:0]  addr_n;
    logic        wr_n, done_n, err_n;
    logic [7:0]  addr;
    logic [9:0]  bit_idx;
    logic        opp_ok, accept, x_ok, on_table;

    assign addr     = 8'(inter_block_y) * 8'd18 + 8'(inter_block_x);
    assign bit_idx  = 10'(addr) * 10'd6;
    assign opp_ok   = cur_game_state == ((PLAYER == `P1) ? `GAME_P2_WAIT_IN : `GAME_P1_WAIT_IN);
    assign rx_ready = (state == IDLE) || (state == HOLD);
    assign accept   = inter_en && rx_ready && opp_ok;
    assign x_ok     = inter_block_x <= 5'd17;
    assign on_table = inter_block_y < 3'd6;

    always_comb begin
        state_n = state;
        held_n  = held_card;
        err_n   = proto_err;
        wr_n    = 1'b0;
        done_n  = 1'b0;
        addr_n  = map_wr_addr;
        data_n  = map_wr_data;
        if (inter_en && (!accept || !x_ok))
            err_n = 1'b1;
        case (state)
            IDLE: if (accept && x_ok) begin
                if (inter_msg_type == `MSG_TABLE_TAKE && on_table) begin
                    held_n  = map[bit_idx +: 6];
                    addr_n  = addr[6:0];
                    data_n  = EMPTY_CARD;
                    wr_n    = 1'b1;
                    state_n = WR_TAKE;
                end else if (inter_msg_type == `MSG_HAND_DOWN && !on_table) begin
                    held_n  = inter_card;
                    state_n = HOLD;
                end else
                    err_n = 1'b1;
            end
            WR_TAKE: state_n = HOLD;
            HOLD: if (accept && x_ok) begin
                if (inter_msg_type == `MSG_TABLE_DOWN && on_table) begin
                    addr_n  = addr[6:0];
                    data_n  = held_card;
                    wr_n    = 1'b1;
                    state_n = WR_DOWN;
                    // A mismatching card is flagged but the tracked card still wins.
                    if (inter_card != held_card && inter_card != 6'd0)
                        err_n = 1'b1;
                end else if (inter_msg_type == `MSG_HAND_DOWN && !on_table) begin
                    held_n  = EMPTY_CARD;
                    done_n  = 1'b1;
                    state_n = DONE;
                end else
                    err_n = 1'b1;
            end
            WR_DOWN: begin
                held_n  = EMPTY_CARD;
                done_n  = 1'b1;
                state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst || interboard_rst) begin
            state            <= IDLE;
            held_card        <= EMPTY_CARD;
            proto_err        <= 1'b0;
            map_wr_en        <= 1'b0;
            map_wr_addr      <= 7'd0;
            map_wr_data      <= 6'd0;
            remote_move_done <= 1'b0;
        end else begin
            state            <= state_n;
            held_card        <= held_n;
            proto_err        <= err_n;
            map_wr_en        <= wr_n;
            map_wr_addr      <= addr_n;
            map_wr_data      <= data_n;
            remote_move_done <= done_n;
        end
    end
endmodule

// File: tb/tb_remote_move_apply.sv
// tb_remote_move_apply: directed stimulus with a queued scoreboard checked by a separate monitor.
module tb_remote_move_apply;
    localparam logic [3:0] GS_P1 = 4'd3, GS_P2 = 4'd4;
    localparam logic [3:0] TT = 4'd1, TD = 4'd2, HD = 4'd3;

    typedef struct {
        bit       is_done;
        int       addr;
        int       data;
        int       cyc;
    } ev_t;

    logic         clk = 0, rst = 0, interboard_rst = 0, inter_en = 0;
    logic [3:0]   cur_game_state = GS_P2, inter_msg_type = 0;
    logic [4:0]   inter_block_x = 0;
    logic [2:0]   inter_block_y = 0;
    logic [5:0]   inter_card = 0;
    logic [863:0] map = '0;
    logic         rx_ready, map_wr_en, remote_move_done, proto_err;
    logic [6:0]   map_wr_addr;
    logic [5:0]   map_wr_data, held_card;

    int checks = 0, failures = 0, cyc = 0;
    ev_t exp_q[$];

    remote_move_apply dut (
        .clk(clk), .rst(rst), .interboard_rst(interboard_rst),
        .cur_game_state(cur_game_state), .inter_en(inter_en),
        .inter_msg_type(inter_msg_type), .inter_block_x(inter_block_x),
        .inter_block_y(inter_block_y), .inter_card(inter_card), .map(map),
        .rx_ready(rx_ready), .map_wr_en(map_wr_en), .map_wr_addr(map_wr_addr),
        .map_wr_data(map_wr_data), .held_card(held_card),
        .remote_move_done(remote_move_done), .proto_err(proto_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (map_wr_en || remote_move_done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: wr_en=%0b done=%0b addr=%0d data=%0d expected none",
                         map_wr_en, remote_move_done, map_wr_addr, map_wr_data);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("ev_kind_done", int'(remote_move_done), int'(e.is_done));
                chk("ev_cycle", cyc, e.cyc);
                if (e.is_done)
                    chk("done_held", int'(held_card), e.data);
                else begin
                    chk("wr_addr", int'(map_wr_addr), e.addr);
                    chk("wr_data", int'(map_wr_data), e.data);
                end
            end
        end
    end

    task automatic send(input logic [3:0] t, input int x, input int y, input int card, output int n);
        @(posedge clk) #1;
        inter_en = 1; inter_msg_type = t;
        inter_block_x = 5'(x); inter_block_y = 3'(y); inter_card = 6'(card);
        n = cyc;
        @(posedge clk) #1;
        inter_en = 0;
    endtask

    task automatic push(input bit d, input int a, input int v, input int c);
        ev_t e;
        e.is_done = d; e.addr = a; e.data = v; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk) #1 rst = 0;
        idle(3);
        rst = 1;
        idle(1);
    endtask

    initial begin
        int n;
        map[39*6 +: 6] = 6'd17;
        map[0 +: 6]    = 6'd9;
        idle(3);
        rst = 1;
        idle(1);
        chk("rst_held", held_card, 54);
        chk("rst_ready", rx_ready, 1);
        chk("rst_wr_en", map_wr_en, 0);
        chk("rst_done", remote_move_done, 0);
        chk("rst_err", proto_err, 0);
        chk("rst_addr", map_wr_addr, 0);
        chk("rst_data", map_wr_data, 0);

        // Table to table move: take (3,2)=17, put it down at (10,4).
        push(0, 39, 54, cyc + 2);
        send(TT, 3, 2, 0, n);
        chk("take_held", held_card, 17);
        chk("take_ready_busy", rx_ready, 0);
        idle(1);
        chk("hold_ready", rx_ready, 1);
        push(0, 82, 17, cyc + 2);
        push(1, 0, 54, cyc + 3);
        send(TD, 10, 4, 17, n);
        idle(3);
        chk("move1_err", proto_err, 0);
        chk("move1_held", held_card, 54);
        chk("move1_ready", rx_ready, 1);

        // Hand to table: card 33 comes from the opponent's hand, lands on (0,0).
        send(HD, 0, 6, 33, n);
        chk("hand_held", held_card, 33);
        idle(1);
        push(0, 0, 33, cyc + 2);
        push(1, 0, 54, cyc + 3);
        send(TD, 0, 0, 33, n);
        idle(3);
        chk("move2_err", proto_err, 0);
        chk("move2_held", held_card, 54);

        // Take then return to hand: only the take clears the cell.
        push(0, 39, 54, cyc + 2);
        send(TT, 3, 2, 0, n);
        idle(1);
        push(1, 0, 54, cyc + 2);
        send(HD, 4, 7, 17, n);
        idle(2);
        chk("ret_err", proto_err, 0);
        chk("ret_held", held_card, 54);

        send(TD, 1, 1, 5, n);
        idle(2);
        chk("idle_down_err", proto_err, 1);
        chk("idle_down_held", held_card, 54);
        do_reset();
        chk("rst2_err", proto_err, 0);

        send(TT, 20, 2, 0, n);
        idle(2);
        chk("badx_err", proto_err, 1);
        chk("badx_ready", rx_ready, 1);
        chk("badx_held", held_card, 54);
        do_reset();

        cur_game_state = GS_P1;
        send(TT, 3, 2, 0, n);
        idle(2);
        chk("turn_err", proto_err, 1);
        chk("turn_held", held_card, 54);
        cur_game_state = GS_P2;
        do_reset();

        // Down with a mismatching card still writes the tracked card.
        push(0, 39, 54, cyc + 2);
        send(TT, 3, 2, 0, n);
        idle(1);
        push(0, 19, 17, cyc + 2);
        push(1, 0, 54, cyc + 3);
        send(TD, 1, 1, 5, n);
        idle(3);
        chk("mism_err", proto_err, 1);
        do_reset();

        push(0, 39, 54, cyc + 2);
        send(TT, 3, 2, 0, n);
        idle(1);
        chk("mid_held_pre", held_card, 17);
        interboard_rst = 1;
        idle(1);
        interboard_rst = 0;
        chk("mid_held", held_card, 54);
        chk("mid_ready", rx_ready, 1);
        chk("mid_wr_en", map_wr_en, 0);
        chk("mid_err", proto_err, 0);
        idle(4);
        chk("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim did not finish");
        $fatal(1);
    end
endmodule

// File: doc/remote_move_apply.md
Name: remote_move_apply

Overview:
- Receive-side counterpart of the local move initiator. It consumes decoded inter-board move messages (TABLE_TAKE / TABLE_DOWN / HAND_DOWN) sent by the opponent's board.
- Replays each take/down pair onto the local 8x18 card map as single-cell write pulses.
- Tracks the card currently "in the opponent's hand" between the take and the down.
- Sits between the inter-board receiver and the map register file. It fires move-done when a remote move completes.

Parameters:
- PLAYER, 0, identity of this board (`P1/`P2). Messages are applied only while the game state is the opponent's wait-in state.
- EMPTY_CARD, 54, card code meaning "no card"; written into cleared cells and used as the held-card idle value.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- interboard_rst  in  1  synchronous reset from the link, active-high; same effect as rst
- cur_game_state  in  4  global game FSM state
- inter_en  in  1  one-cycle pulse: decoded message valid
- inter_msg_type  in  4  message type, encoded per the shared message header
- inter_block_x  in  5  column, 0..17
- inter_block_y  in  3  row; 0..5 table, 6..7 hand
- inter_card  in  6  card code carried by the message
- map  in  864  current map, 6 bits per cell, cell index 18*y+x
- rx_ready  out  1  high when a message can be accepted
- map_wr_en  out  1  one-cycle map write strobe
- map_wr_addr  out  7  cell index 0..143
- map_wr_data  out  6  card written
- held_card  out  6  card the opponent currently holds; EMPTY_CARD when none
- remote_move_done  out  1  one-cycle pulse after a completed take+down
- proto_err  out  1  sticky error flag; cleared only by reset

Behaviour:
- Reset (rst low, async; or interboard_rst high, sync, with priority over every other event):
  - state=IDLE, held_card=EMPTY_CARD
  - map_wr_en=0, map_wr_addr=0, map_wr_data=0
  - remote_move_done=0, proto_err=0
  - A reset mid-move discards the held card; no write is issued.
- Acceptance: a message is accepted only in the cycle where inter_en=1, rx_ready=1 and the opponent-state condition holds. The opponent-state condition is cur_game_state==`GAME_P2_WAIT_IN for PLAYER=`P1, else `GAME_P1_WAIT_IN.
- inter_en while rx_ready=0, or outside the opponent state: message ignored, proto_err<=1.
- rx_ready=1 only in IDLE and HOLD.
- Address: addr=18*y+x, computed at 8-bit width. x>17 sets proto_err and the message is ignored; state does not change.
- States:
  - IDLE
    - Accepts a TABLE_TAKE with y<6: latch held_card<=map[addr*6+:6] and latch addr; go to WR_TAKE.
    - Accepts a HAND_DOWN with y>=6 (take from the opponent's own hand): held_card<=inter_card; go to HOLD. No local write.
    - Any other type: proto_err<=1, stay in IDLE.
  - WR_TAKE: map_wr_en=1, map_wr_addr=latched addr, map_wr_data=EMPTY_CARD for exactly this one cycle; go to HOLD. Latency from the accepting cycle to the strobe is 1 cycle.
  - HOLD
    - Accepts TABLE_DOWN with y<6: latch addr; data=held_card; go to WR_DOWN.
    - If inter_card != held_card and inter_card != 0: proto_err<=1, but held_card is still written.
    - Accepts HAND_DOWN with y>=6: card returns to the opponent's hand, no write; go to DONE.
    - A second TABLE_TAKE: proto_err<=1, stay in HOLD.
  - WR_DOWN: one-cycle strobe of held_card to the latched addr; go to DONE.
  - DONE: remote_move_done=1 for one cycle, held_card<=EMPTY_CARD; go to IDLE.
- Outputs are registered. map_wr_en and remote_move_done never stay high for 2 consecutive cycles.
- Game state leaving the opponent state while in HOLD: hold is kept; subsequent messages are rejected until the state returns.

Test Plan:
- Reset then idle: rst low 3 cycles -> held_card=54, rx_ready=1, all strobes 0, proto_err=0.
- Table move, P1 board in `GAME_P2_WAIT_IN with map cell (3,2)=17:
  - TABLE_TAKE x=3,y=2 -> next cycle map_wr_en=1, addr=39, data=54, held_card=17.
  - Then TABLE_DOWN x=10,y=4, card=17 -> strobe addr=82, data=17, then remote_move_done pulse, held_card=54, proto_err=0.
- Hand-to-table move: HAND_DOWN y=6, card=33 -> no strobe, held_card=33. TABLE_DOWN x=0,y=0 -> addr=0, data=33, done pulse.
- Protocol errors:
  - TABLE_DOWN while in IDLE -> proto_err=1, no strobe.
  - x=20 in TABLE_TAKE -> proto_err=1, state stays IDLE.
- Wrong turn: TABLE_TAKE while cur_game_state=`GAME_P1_WAIT_IN on PLAYER=`P1 -> ignored, proto_err=1, held_card=54.
- Mid-move reset: in HOLD with held_card=17, assert interboard_rst 1 cycle -> IDLE, held_card=54, no write, rx_ready=1 the next cycle.
